// File: rtl/hc595_frame_rx.sv
// Receiver for the 74HC595 serial display link: oversamples the link pins, rebuilds the
// shift/storage registers, checks each latched frame and keeps a decoded 6-digit display image.
module hc595_frame_rx #(
    parameter int unsigned FRAME_BITS     = 14,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shcp_595,
    input  logic        stcp_595,
    input  logic        ds,
    input  logic        oe_595,
    output logic        frame_valid,
    output logic [7:0]  frame_seg,
    output logic [5:0]  frame_sel,
    output logic        frame_err,
    output logic [23:0] disp_code,
    output logic [5:0]  disp_dp,
    output logic        disp_on
);

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned SEL_W  = 6;
    localparam int unsigned DIGITS = 6;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IMG_W  = DIGITS * CODE_W;

    // Clock pins carry a third stage for edge detection; ds/oe match the same sync depth.
    logic [2:0] shcp_q;
    logic [2:0] stcp_q;
    logic [1:0] ds_q;
    logic [1:0] oe_q;

    logic [FRAME_BITS-1:0] sr_q,          sr_d;
    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q,   frame_err_d;
    logic [SEG_W-1:0]      frame_seg_q,   frame_seg_d;
    logic [SEL_W-1:0]      frame_sel_q,   frame_sel_d;
    logic [IMG_W-1:0]      disp_code_q,   disp_code_d;
    logic [DIGITS-1:0]     disp_dp_q,     disp_dp_d;
    logic                  disp_on_q,     disp_on_d;

    logic                  shcp_rise_c;
    logic                  stcp_rise_c;
    logic [SEG_W-1:0]      latch_seg_c;
    logic [SEL_W-1:0]      latch_sel_c;
    logic [SEG_W-1:0]      seg_norm_c;
    logic [SEL_W-1:0]      sel_norm_c;
    logic                  sel_onehot_c;
    logic                  frame_bad_c;
    logic [CODE_W-1:0]     seg_code_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shcp_q <= '0;
            stcp_q <= '0;
            ds_q   <= '0;
            oe_q   <= '0;
        end else begin
            shcp_q <= {shcp_q[1:0], shcp_595};
            stcp_q <= {stcp_q[1:0], stcp_595};
            ds_q   <= {ds_q[0], ds};
            oe_q   <= {oe_q[0], oe_595};
        end
    end

    assign shcp_rise_c = shcp_q[1] & ~shcp_q[2];
    assign stcp_rise_c = stcp_q[1] & ~stcp_q[2];

    // Latch always sees the pre-shift register, as the real 595 does on coincident edges.
    assign latch_seg_c  = sr_q[FRAME_BITS-1 -: SEG_W];
    assign latch_sel_c  = sr_q[SEL_W-1:0];
    assign seg_norm_c   = (SEG_ACTIVE_LOW != 0) ? latch_seg_c : ~latch_seg_c;
    assign sel_norm_c   = (SEL_ACTIVE_LOW != 0) ? ~latch_sel_c : latch_sel_c;
    assign sel_onehot_c = (sel_norm_c != '0) && ((sel_norm_c & (sel_norm_c - SEL_W'(1))) == '0);
    assign frame_bad_c  = (bit_cnt_q != CNT_W'(FRAME_BITS)) || !sel_onehot_c;

    // Active-low 7-segment pattern to digit code; dp bit is not part of the match.
    always_comb begin
        seg_code_c = 4'd14;
        case (seg_norm_c[6:0])
            7'h40:   seg_code_c = 4'd0;
            7'h79:   seg_code_c = 4'd1;
            7'h24:   seg_code_c = 4'd2;
            7'h30:   seg_code_c = 4'd3;
            7'h19:   seg_code_c = 4'd4;
            7'h12:   seg_code_c = 4'd5;
            7'h02:   seg_code_c = 4'd6;
            7'h78:   seg_code_c = 4'd7;
            7'h00:   seg_code_c = 4'd8;
            7'h10:   seg_code_c = 4'd9;
            7'h3F:   seg_code_c = 4'd10;
            7'h7F:   seg_code_c = 4'd15;
            default: seg_code_c = 4'd14;
        endcase
    end

    always_comb begin
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_seg_d   = frame_seg_q;
        frame_sel_d   = frame_sel_q;
        disp_code_d   = disp_code_q;
        disp_dp_d     = disp_dp_q;
        disp_on_d     = ~oe_q[1];

        if (shcp_rise_c) begin
            sr_d = {sr_q[FRAME_BITS-2:0], ds_q[1]};
            if (bit_cnt_q != '1) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        if (stcp_rise_c) begin
            frame_valid_d = 1'b1;
            frame_err_d   = frame_bad_c;
            frame_seg_d   = latch_seg_c;
            frame_sel_d   = latch_sel_c;
            bit_cnt_d     = shcp_rise_c ? CNT_W'(1) : CNT_W'(0);
            if (!frame_bad_c) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_norm_c[i]) begin
                        disp_code_d[CODE_W*i +: CODE_W] = seg_code_c;
                        disp_dp_d[i]                    = ~seg_norm_c[7];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_seg_q   <= '0;
            frame_sel_q   <= '0;
            disp_code_q   <= '1;
            disp_dp_q     <= '0;
            disp_on_q     <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_seg_q   <= frame_seg_d;
            frame_sel_q   <= frame_sel_d;
            disp_code_q   <= disp_code_d;
            disp_dp_q     <= disp_dp_d;
            disp_on_q     <= disp_on_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_seg   = frame_seg_q;
    assign frame_sel   = frame_sel_q;
    assign disp_code   = disp_code_q;
    assign disp_dp     = disp_dp_q;
    assign disp_on     = disp_on_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Directed bench for hc595_frame_rx: drives the 595 link pins and checks frames and display image.
module tb_hc595_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        shcp_595, stcp_595, ds, oe_595;
    logic        frame_valid, frame_err;
    logic [7:0]  frame_seg;
    logic [5:0]  frame_sel;
    logic [23:0] disp_code;
    logic [5:0]  disp_dp;
    logic        disp_on;

    logic        ah_valid, ah_err;
    logic [7:0]  ah_seg;
    logic [5:0]  ah_sel;
    logic [23:0] ah_code;
    logic [5:0]  ah_dp;
    logic        ah_on;

    int          n_chk  = 0;
    int          n_pass = 0;

    int          lat_r;
    logic        err_r;
    logic [7:0]  seg_r;
    logic [5:0]  sel_r;
    logic [23:0] code_r;
    logic [5:0]  dp_r;

    always #5 clk = ~clk;

    hc595_frame_rx u_dut (
        .clk(clk), .rst_n(rst_n), .shcp_595(shcp_595), .stcp_595(stcp_595), .ds(ds),
        .oe_595(oe_595), .frame_valid(frame_valid), .frame_seg(frame_seg),
        .frame_sel(frame_sel), .frame_err(frame_err), .disp_code(disp_code),
        .disp_dp(disp_dp), .disp_on(disp_on)
    );

    // Active-high segment build shares the same link.
    hc595_frame_rx #(.SEG_ACTIVE_LOW(0)) u_dut_ah (
        .clk(clk), .rst_n(rst_n), .shcp_595(shcp_595), .stcp_595(stcp_595), .ds(ds),
        .oe_595(oe_595), .frame_valid(ah_valid), .frame_seg(ah_seg),
        .frame_sel(ah_sel), .frame_err(ah_err), .disp_code(ah_code),
        .disp_dp(ah_dp), .disp_on(ah_on)
    );

    task automatic shift_bit(input logic b);
        @(negedge clk); ds = b;
        repeat (2) @(negedge clk);
        shcp_595 = 1'b1;
        repeat (2) @(negedge clk);
        shcp_595 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    // Raise stcp (optionally with shcp in the same cycle) and capture the frame_valid cycle.
    task automatic do_latch(input logic with_shift);
        logic got;
        got   = 1'b0;
        lat_r = 0;
        @(negedge clk);
        stcp_595 = 1'b1;
        if (with_shift) shcp_595 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (!got && frame_valid === 1'b1) begin
                got = 1'b1; lat_r = i; err_r = frame_err; seg_r = frame_seg;
                sel_r = frame_sel; code_r = disp_code; dp_r = disp_dp;
            end
        end
        @(negedge clk);
        stcp_595 = 1'b0;
        shcp_595 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; shcp_595 = 1'b0; stcp_595 = 1'b0; ds = 1'b0; oe_595 = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (disp_code !== 24'hFFFFFF) $display("FAIL rst_code got %h want ffffff", disp_code); else n_pass++;
        n_chk++; if (disp_dp !== 6'h00) $display("FAIL rst_dp got %h want 00", disp_dp); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", frame_valid); else n_pass++;
        n_chk++; if (disp_on !== 1'b0) $display("FAIL rst_on got %b want 0", disp_on); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        send_bits(64'({8'hC0, 6'b111110}), 14);
        do_latch(1'b0);
        n_chk++; if (lat_r !== 3) $display("FAIL single_latency got %0d want 3", lat_r); else n_pass++;
        n_chk++; if (err_r !== 1'b0) $display("FAIL single_err got %b want 0", err_r); else n_pass++;
        n_chk++; if (seg_r !== 8'hC0) $display("FAIL single_seg got %h want c0", seg_r); else n_pass++;
        n_chk++; if (sel_r !== 6'h3E) $display("FAIL single_sel got %h want 3e", sel_r); else n_pass++;
        n_chk++; if (code_r !== 24'hFFFFF0) $display("FAIL single_code got %h want fffff0", code_r); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL single_pulse got %b want 0", frame_valid); else n_pass++;
    endtask

    task automatic test_six_digits();
        send_bits(64'({8'hF9, 6'b111110}), 14); do_latch(1'b0);
        send_bits(64'({8'hA4, 6'b111101}), 14); do_latch(1'b0);
        send_bits(64'({8'hBF, 6'b111011}), 14); do_latch(1'b0);
        send_bits(64'({8'hBF, 6'b110111}), 14); do_latch(1'b0);
        send_bits(64'({8'h99, 6'b101111}), 14); do_latch(1'b0);
        send_bits(64'({8'h92, 6'b011111}), 14); do_latch(1'b0);
        n_chk++; if (code_r !== 24'h54AA21) $display("FAIL six_code got %h want 54aa21", code_r); else n_pass++;
        n_chk++; if (dp_r !== 6'h00) $display("FAIL six_dp got %h want 00", dp_r); else n_pass++;
        send_bits(64'({8'h40, 6'b111110}), 14); do_latch(1'b0);
        n_chk++; if (code_r !== 24'h54AA20) $display("FAIL dp_code got %h want 54aa20", code_r); else n_pass++;
        n_chk++; if (dp_r !== 6'h01) $display("FAIL dp_lit got %h want 01", dp_r); else n_pass++;
    endtask

    task automatic test_errors();
        // 13 bits: bit 13 of the shift register is the stale last bit (0) of the previous frame.
        send_bits(64'({8'hF9, 6'b111101}), 13); do_latch(1'b0);
        n_chk++; if (lat_r !== 3) $display("FAIL short_valid got %0d want 3", lat_r); else n_pass++;
        n_chk++; if (err_r !== 1'b1) $display("FAIL short_err got %b want 1", err_r); else n_pass++;
        n_chk++; if (seg_r !== 8'h79) $display("FAIL short_seg got %h want 79", seg_r); else n_pass++;
        n_chk++; if (sel_r !== 6'h3D) $display("FAIL short_sel got %h want 3d", sel_r); else n_pass++;
        n_chk++; if (code_r !== 24'h54AA20) $display("FAIL short_img got %h want 54aa20", code_r); else n_pass++;
        send_bits(64'({8'hF9, 6'b111100}), 14); do_latch(1'b0);
        n_chk++; if (err_r !== 1'b1) $display("FAIL twohot_err got %b want 1", err_r); else n_pass++;
        n_chk++; if (sel_r !== 6'h3C) $display("FAIL twohot_sel got %h want 3c", sel_r); else n_pass++;
        n_chk++; if (code_r !== 24'h54AA20) $display("FAIL twohot_img got %h want 54aa20", code_r); else n_pass++;
        // 46 shifts: a wrapping 5-bit counter would read 14 and accept this frame.
        send_bits({18'h0, 32'hA5A5_5A5A, 8'hF9, 6'b111101}, 46); do_latch(1'b0);
        n_chk++; if (err_r !== 1'b1) $display("FAIL sat_err got %b want 1", err_r); else n_pass++;
        n_chk++; if (seg_r !== 8'hF9) $display("FAIL sat_seg got %h want f9", seg_r); else n_pass++;
        n_chk++; if (code_r !== 24'h54AA20) $display("FAIL sat_img got %h want 54aa20", code_r); else n_pass++;
    endtask

    task automatic test_decode();
        send_bits(64'({8'hAA, 6'b111011}), 14); do_latch(1'b0);
        n_chk++; if (code_r !== 24'h54AE20) $display("FAIL unknown_code got %h want 54ae20", code_r); else n_pass++;
        send_bits(64'({8'h3F, 6'b011111}), 14); do_latch(1'b0);
        n_chk++; if (code_r !== 24'hA4AE20) $display("FAIL dash_code got %h want a4ae20", code_r); else n_pass++;
        n_chk++; if (dp_r !== 6'h21) $display("FAIL dash_dp got %h want 21", dp_r); else n_pass++;
        n_chk++; if (ah_code[23:20] !== 4'h0) $display("FAIL ah_code got %h want 0", ah_code[23:20]); else n_pass++;
        n_chk++; if (ah_dp[5] !== 1'b0) $display("FAIL ah_dp got %b want 0", ah_dp[5]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] fb;
        fb = {8'hB0, 6'b101111};
        send_bits(64'({8'h99, 6'b110111}), 14);
        @(negedge clk); ds = fb[13];
        repeat (2) @(negedge clk);
        do_latch(1'b1);
        n_chk++; if (lat_r !== 3) $display("FAIL b2b_valid got %0d want 3", lat_r); else n_pass++;
        n_chk++; if (err_r !== 1'b0) $display("FAIL b2b_err got %b want 0", err_r); else n_pass++;
        n_chk++; if (seg_r !== 8'h99) $display("FAIL b2b_seg got %h want 99", seg_r); else n_pass++;
        n_chk++; if (code_r !== 24'hA44E20) $display("FAIL b2b_code got %h want a44e20", code_r); else n_pass++;
        send_bits(64'(fb), 13); do_latch(1'b0);
        n_chk++; if (err_r !== 1'b0) $display("FAIL b2b_next_err got %b want 0", err_r); else n_pass++;
        n_chk++; if (seg_r !== 8'hB0) $display("FAIL b2b_next_seg got %h want b0", seg_r); else n_pass++;
        n_chk++; if (sel_r !== 6'h2F) $display("FAIL b2b_next_sel got %h want 2f", sel_r); else n_pass++;
        n_chk++; if (code_r !== 24'hA34E20) $display("FAIL b2b_next_code got %h want a34e20", code_r); else n_pass++;
    endtask

    task automatic test_oe();
        n_chk++; if (disp_on !== 1'b1) $display("FAIL on_default got %b want 1", disp_on); else n_pass++;
        @(negedge clk); oe_595 = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++; if (disp_on !== 1'b0) $display("FAIL oe_off got %b want 0", disp_on); else n_pass++;
        send_bits(64'({8'hC0, 6'b111101}), 14); do_latch(1'b0);
        n_chk++; if (code_r !== 24'hA34E00) $display("FAIL oe_img got %h want a34e00", code_r); else n_pass++;
        n_chk++; if (disp_on !== 1'b0) $display("FAIL oe_still_off got %b want 0", disp_on); else n_pass++;
        oe_595 = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (disp_on !== 1'b1) $display("FAIL oe_on got %b want 1", disp_on); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        send_bits(64'h15, 5);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (disp_code !== 24'hFFFFFF) $display("FAIL mid_rst_code got %h want ffffff", disp_code); else n_pass++;
        n_chk++; if (disp_dp !== 6'h00) $display("FAIL mid_rst_dp got %h want 00", disp_dp); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(64'({8'hB0, 6'b111110}), 14); do_latch(1'b0);
        n_chk++; if (err_r !== 1'b0) $display("FAIL mid_err got %b want 0", err_r); else n_pass++;
        n_chk++; if (code_r !== 24'hFFFFF3) $display("FAIL mid_code got %h want fffff3", code_r); else n_pass++;
        send_bits(64'({8'hF9, 6'b111110}), 10); do_latch(1'b0);
        n_chk++; if (err_r !== 1'b1) $display("FAIL mid_short_err got %b want 1", err_r); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_six_digits();
        test_errors();
        test_decode();
        test_back_to_back();
        test_oe();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
